// File: rtl/des_pkg.sv
// Shared types and constants for the DES round sequencer and its integration.
package des_pkg;

    localparam int DES_BLOCK_W = 64;
    localparam int DES_ROUNDS  = 16;
    localparam int ROUNDSEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    // Classic textbook DES vector: key 133457799BBCDFF1 maps this plaintext to this ciphertext.
    localparam logic [0:DES_BLOCK_W-1] TV_KEY    = 64'h133457799BBCDFF1;
    localparam logic [0:DES_BLOCK_W-1] TV_PLAIN  = 64'h0123456789ABCDEF;
    localparam logic [0:DES_BLOCK_W-1] TV_CIPHER = 64'h85E813540F0AB405;

endpackage

// File: rtl/des_seq_ctrl.sv
// Drives an iterative single-round DES core: latches one block, steps roundSel
// through every round, waits out the core latency and hands back the result.
module des_seq_ctrl
    import des_pkg::*;
#(
    parameter int ROUNDS   = DES_ROUNDS,
    parameter int CORE_LAT = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:DES_BLOCK_W-1]  in_data,
    input  logic [0:DES_BLOCK_W-1]  in_key,
    input  logic                    in_decrypt,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [0:DES_BLOCK_W-1]  out_data,
    output logic                    busy,
    output logic [0:DES_BLOCK_W-1]  core_desIn,
    output logic [0:DES_BLOCK_W-1]  core_key,
    output logic                    core_decrypt,
    output logic [0:ROUNDSEL_W-1]   core_roundSel,
    input  logic [0:DES_BLOCK_W-1]  core_desOut
);

    localparam int CNT_W = 2;
    localparam logic [0:ROUNDSEL_W-1] LAST_ROUND = ROUNDSEL_W'(ROUNDS - 1);
    localparam logic [CNT_W-1:0]      WAIT_INIT  = CNT_W'(CORE_LAT - 1);

    seq_state_e               state_q, state_d;
    logic [0:ROUNDSEL_W-1]    round_q, round_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic                     outValid_q, outValid_d;
    logic [0:DES_BLOCK_W-1]   outData_q, outData_d;
    logic [0:DES_BLOCK_W-1]   desIn_q, desIn_d;
    logic [0:DES_BLOCK_W-1]   key_q, key_d;
    logic                     decrypt_q, decrypt_d;
    logic                     accept;

    // A DONE slot frees up on the same edge the consumer takes the result,
    // so a waiting request can be taken without an idle bubble.
    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    assign busy          = (state_q == RUN) | (state_q == WAIT);
    assign out_valid     = outValid_q;
    assign out_data      = outData_q;
    assign core_desIn    = desIn_q;
    assign core_key      = key_q;
    assign core_decrypt  = decrypt_q;
    assign core_roundSel = round_q;

    always_comb begin
        state_d    = state_q;
        round_d    = round_q;
        count_d    = count_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        desIn_d    = desIn_q;
        key_d      = key_q;
        decrypt_d  = decrypt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    desIn_d   = in_data;
                    key_d     = in_key;
                    decrypt_d = in_decrypt;
                    round_d   = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // round_q returns to zero on exit so roundSel idles at 0.
                if (round_q == LAST_ROUND) begin
                    round_d = '0;
                    count_d = WAIT_INIT;
                    state_d = WAIT;
                end else begin
                    round_d = round_q + ROUNDSEL_W'(1);
                end
            end
            WAIT: begin
                if (count_q == '0) begin
                    outData_d  = core_desOut;
                    outValid_d = 1'b1;
                    state_d    = DONE;
                end else begin
                    count_d = count_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    outValid_d = 1'b0;
                    if (accept) begin
                        desIn_d   = in_data;
                        key_d     = in_key;
                        decrypt_d = in_decrypt;
                        round_d   = '0;
                        state_d   = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            round_q    <= '0;
            count_q    <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            desIn_q    <= '0;
            key_q      <= '0;
            decrypt_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            round_q    <= round_d;
            count_q    <= count_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            desIn_q    <= desIn_d;
            key_q      <= key_d;
            decrypt_q  <= decrypt_d;
        end
    end

endmodule

// File: tb/tb_des_seq_ctrl.sv
// Self-checking bench for des_seq_ctrl; a stand-in DES core answers the known
// vectors and otherwise returns a keyed scramble, one edge after round 15.
module tb_des_seq_ctrl;

    localparam int ROUNDS   = 16;
    localparam int CORE_LAT = 1;
    localparam int LAT      = ROUNDS + CORE_LAT;

    localparam logic [0:63] KEY    = 64'h133457799BBCDFF1;
    localparam logic [0:63] PLAIN  = 64'h0123456789ABCDEF;
    localparam logic [0:63] CIPHER = 64'h85E813540F0AB405;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:63] in_data = '0;
    logic [0:63] in_key = '0;
    logic        in_decrypt = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [0:63] out_data;
    logic        busy;
    logic [0:63] core_desIn;
    logic [0:63] core_key;
    logic        core_decrypt;
    logic [0:3]  core_roundSel;
    logic [0:63] core_desOut = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_seq_ctrl #(.ROUNDS(ROUNDS), .CORE_LAT(CORE_LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy),
        .core_desIn(core_desIn), .core_key(core_key), .core_decrypt(core_decrypt),
        .core_roundSel(core_roundSel), .core_desOut(core_desOut)
    );

    function automatic logic [0:63] coreFunc(input logic [0:63] d, input logic [0:63] k, input logic dec);
        if (d == PLAIN && k == KEY && !dec) return CIPHER;
        if (d == CIPHER && k == KEY && dec) return PLAIN;
        return d ^ {k[32:63], k[0:31]} ^ {64{dec}};
    endfunction

    // The result is only meaningful on the edge after the core saw round 15.
    always @(posedge clk) begin
        if (core_roundSel == 4'd15)
            core_desOut <= coreFunc(core_desIn, core_key, core_decrypt);
        else
            core_desOut <= {$urandom, $urandom};
    end

    // Reference: a block is owned from its accept edge until its result is taken;
    // everything follows from how many edges have passed since the accept.
    bit          mValid = 0;
    bit          mBlock = 0;
    bit          mAccepted = 0;
    int          mAge = 0;
    logic [0:63] mRes = '0, mDin = '0, mKey = '0, mOutData = '0;
    logic        mDec = 0;

    task automatic checkWide(input string name, input logic [0:63] act, input logic [0:63] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit hv;
        if (!mValid) return;
        hv = mBlock && (mAge >= LAT);
        checkWide("in_ready", 64'(in_ready), 64'(!mBlock || (hv && out_ready)));
        checkWide("out_valid", 64'(out_valid), 64'(hv));
        checkWide("busy", 64'(busy), 64'(mBlock && !hv));
        checkWide("roundSel", {60'd0, core_roundSel}, (mBlock && mAge < ROUNDS) ? 64'(mAge) : 64'd0);
        checkWide("core_desIn", core_desIn, mDin);
        checkWide("core_key", core_key, mKey);
        checkWide("core_decrypt", 64'(core_decrypt), 64'(mDec));
        if (hv) checkWide("out_data", out_data, mOutData);
    endtask

    task automatic modelEdge();
        bit hv, rdy, acc, hs;
        if (reset) begin
            mValid = 1; mBlock = 0; mAge = 0; mAccepted = 0;
            mDin = '0; mKey = '0; mDec = 0; mOutData = '0;
            return;
        end
        hv  = mBlock && (mAge >= LAT);
        rdy = !mBlock || (hv && out_ready);
        acc = in_valid && rdy;
        hs  = hv && out_ready;
        mAccepted = acc;
        if (mBlock && !hv) begin
            mAge++;
            if (mAge == LAT) mOutData = mRes;
        end
        if (hs) mBlock = 0;
        if (acc) begin
            mBlock = 1; mAge = 0;
            mDin = in_data; mKey = in_key; mDec = in_decrypt;
            mRes = coreFunc(in_data, in_key, in_decrypt);
        end
    endtask

    // One cycle: drive inputs after the falling edge, check, then take the rising edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic [0:63] d, input logic [0:63] k,
                                 input logic dec, input logic ordy, output logic ov, output logic [0:63] od);
        reset = rst; in_valid = v; in_data = d; in_key = k; in_decrypt = dec; out_ready = ordy;
        #1;
        checkOutput();
        ov = out_valid;
        od = out_data;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic presentUntilAccepted(input string name, input logic [0:63] d, input logic [0:63] k,
                                        input logic dec, input int readyPct, output bit ok);
        logic ov;
        logic [0:63] od;
        ok = 0;
        for (int n = 0; n < 40 && !ok; n++) begin
            applyStimulus(1'b0, 1'b1, d, k, dec, $urandom_range(99) < readyPct, ov, od);
            ok = mAccepted;
        end
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s_accept_timeout: got no accept expected accept within 40 cycles", name);
        end
    endtask

    task automatic runTransaction(input string name, input logic [0:63] d, input logic [0:63] k,
                                  input logic dec, input logic [0:63] expOut, input int readyPct);
        bit ok, seen, done;
        logic ov, ordy;
        logic [0:63] od;
        presentUntilAccepted(name, d, k, dec, readyPct, ok);
        if (!ok) return;
        seen = 0; done = 0;
        for (int lat = 0; lat < 120 && !done; lat++) begin
            ordy = $urandom_range(99) < readyPct;
            applyStimulus(1'b0, 1'b0, {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, ordy, ov, od);
            if (ov && !seen) begin
                seen = 1;
                checkInt({name, "_latency"}, lat, LAT);
                checkWide({name, "_result"}, od, expOut);
            end
            if (ov && ordy) done = 1;
        end
        if (!done) begin
            errors++;
            $display("[TB] FAIL %s_result_timeout: got no handshake expected one within 120 cycles", name);
        end
    endtask

    task automatic drain();
        logic ov;
        logic [0:63] od;
        for (int n = 0; n < 60 && mBlock; n++)
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, ov, od);
        checkInt("drain_idle", int'(mBlock), 0);
    endtask

    typedef struct {
        string       name;
        logic [0:63] data;
        logic [0:63] key;
        logic        dec;
        int          readyPct;
        logic [0:63] expOut;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic ov;
        logic [0:63] od, hold, rnd, rkey;
        bit ok;
        int firstV, secondV, ovCount;

        rnd  = 64'hDEADBEEFCAFEF00D;
        rkey = 64'h0F1E2D3C4B5A6978;
        vecs[0] = '{"enc_kat",      PLAIN,  KEY,  1'b0, 100, CIPHER};
        vecs[1] = '{"dec_kat",      CIPHER, KEY,  1'b1, 100, PLAIN};
        vecs[2] = '{"enc_rand",     rnd,    rkey, 1'b0, 50,  rnd ^ {rkey[32:63], rkey[0:31]}};
        vecs[3] = '{"dec_rand",     rnd,    rkey, 1'b1, 30,  ~(rnd ^ {rkey[32:63], rkey[0:31]})};
        vecs[4] = '{"enc_kat_slow", PLAIN,  KEY,  1'b0, 20,  CIPHER};
        vecs[5] = '{"dec_kat_slow", CIPHER, KEY,  1'b1, 15,  PLAIN};

        @(negedge clk);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, ov, od);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, ov, od);
        reset = 1'b0;
        #1;
        checkWide("rst_out_data", out_data, '0);
        checkWide("rst_out_valid", 64'(out_valid), '0);
        checkWide("rst_in_ready", 64'(in_ready), 64'd1);
        checkWide("rst_core_desIn", core_desIn, '0);

        for (int i = 0; i < 6; i++)
            runTransaction(vecs[i].name, vecs[i].data, vecs[i].key, vecs[i].dec, vecs[i].expOut, vecs[i].readyPct);
        drain();

        $display("[TB] backpressure sequence");
        presentUntilAccepted("bp", PLAIN, KEY, 1'b0, 0, ok);
        ovCount = 0;
        for (int n = 0; n < 40 && !out_valid; n++)
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ov, od);
        hold = out_data;
        checkWide("bp_result", hold, CIPHER);
        for (int n = 0; n < 10; n++) begin
            applyStimulus(1'b0, 1'b1, rnd, rkey, 1'b1, 1'b0, ov, od);
            checkWide("bp_hold", od, hold);
            if (!ov) ovCount++;
        end
        checkInt("bp_valid_dropped", ovCount, 0);
        applyStimulus(1'b0, 1'b1, rnd, rkey, 1'b1, 1'b1, ov, od);
        checkInt("bp_release_accept", int'(mAccepted), 1);
        #1;
        checkWide("bp_valid_after", 64'(out_valid), '0);
        drain();

        $display("[TB] back-to-back sequence");
        presentUntilAccepted("b2b", PLAIN, KEY, 1'b0, 100, ok);
        firstV = -1; secondV = -1;
        for (int s = 0; s < 60 && secondV < 0; s++) begin
            applyStimulus(1'b0, 1'b1, CIPHER, KEY, 1'b1, 1'b1, ov, od);
            if (ov) begin
                if (firstV < 0) begin
                    firstV = s;
                    checkWide("b2b_first", od, CIPHER);
                end else begin
                    secondV = s;
                    checkWide("b2b_second", od, PLAIN);
                end
            end
        end
        checkInt("b2b_first_lat", firstV, LAT);
        checkInt("b2b_spacing", secondV - firstV, LAT + 1);
        drain();

        $display("[TB] reset mid-run sequence");
        presentUntilAccepted("rst", PLAIN, KEY, 1'b0, 100, ok);
        for (int n = 0; n < 20 && mAge < 7; n++)
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, ov, od);
        checkWide("rst_round7", {60'd0, core_roundSel}, 64'd7);
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, 1'b1, ov, od);
        ovCount = 0;
        for (int n = 0; n < 25; n++) begin
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b1, ov, od);
            if (ov) ovCount++;
        end
        checkInt("rst_no_valid", ovCount, 0);
        runTransaction("rst_fresh", PLAIN, KEY, 1'b0, CIPHER, 100);

        $display("[TB] ignored input sequence");
        presentUntilAccepted("ign", PLAIN, KEY, 1'b0, 100, ok);
        for (int n = 0; n < 12; n++) begin
            applyStimulus(1'b0, n[0], {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, ov, od);
            checkWide("ign_desIn", core_desIn, PLAIN);
        end
        for (int n = 0; n < 20 && !out_valid; n++)
            applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, ov, od);
        checkWide("ign_result", out_data, CIPHER);
        drain();

        $display("[TB] random traffic");
        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(99) == 0, $urandom_range(1) == 1,
                          ($urandom_range(3) == 0) ? PLAIN : {$urandom, $urandom},
                          ($urandom_range(1) == 1) ? KEY : {$urandom, $urandom},
                          $urandom_range(1) == 1, $urandom_range(3) != 0, ov, od);
        end
        drain();
        #1;
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
